pipa_moding_sim: RTL
====================

Name: pipa_moding_sim

Overview:
- Multi-channel successor to the single-counter PIPA 3-3 moding stub in the board top level.
- Sits between the AGC core outputs PIPASW/PIPDAT and the PIPAXp/m, PIPAYp/m, PIPAZp/m inputs.
- Each channel has its own programmable plus/minus split per moding frame, so the bench or monitor can inject non-zero acceleration.
- Adds a per-channel enable (PIPA-fail simulation), frame-boundary config shadowing, and saturating signed pulse accumulators for readback.

Parameters:
- CHANNELS, 3, number of PIPA axes simulated.
- FRAME, 6, PIPASW pulses per moding frame; legal range 2..15.
- CW, 4, width of the frame-position and plus-count fields; must satisfy 2^CW > FRAME.
- AW, 16, width of each signed net-pulse accumulator.

Ports:
- clk, in, 1, prop_clk; the same clock domain as the AGC core.
- rst_n, in, 1, asynchronous active-low reset.
- pipasw, in, 1, AGC PIPASW; a level signal that is synchronous to clk.
- pipdat, in, 1, AGC PIPDAT data pulse.
- enable, in, CHANNELS, per-channel enable; 0 forces that channel's outputs low.
- plus_cnt, in, CHANNELS*CW, requested plus pulses per frame; channel c occupies bits [c*CW +: CW].
- acc_clear, in, 1, synchronous clear of all accumulators.
- pipa_p, out, CHANNELS, plus pulse per channel.
- pipa_m, out, CHANNELS, minus pulse per channel.
- frame_pos, out, CW, current position in the frame, 0..FRAME-1.
- frame_strobe, out, 1, one-cycle pulse when the frame wraps.
- acc, out, CHANNELS*AW, signed net count (plus minus minus) per channel.

Behaviour:
- Reset values (async on rst_n low):
  - frame_pos=0, frame_strobe=0, acc=0.
  - Active plus count for every channel = FRAME/2, rounded down.
  - Internal pipasw and pipdat edge registers = 0.
- PIPASW edge detect:
  - One register holds pipasw from the previous cycle.
  - A rising edge is pipasw=1 with prev=0.
  - An input held high counts once.
- Frame counter:
  - Each rising pipasw edge advances frame_pos by 1, registered with 1-cycle latency.
  - From FRAME-1 the next edge wraps frame_pos to 0.
  - On the wrap edge, frame_strobe=1 for exactly that cycle.
- Config shadowing:
  - plus_cnt is sampled into the active register only on a wrap edge.
  - Changes mid-frame have no effect until the next frame.
  - A sampled value greater than FRAME clamps to FRAME.
- Mode per channel:
  - plus_mode = (frame_pos < active_plus).
  - active_plus=0 gives all-minus; active_plus=FRAME gives all-plus.
- Outputs (combinational from pipdat, registered mode):
  - pipa_p[c] = pipdat & enable[c] & plus_mode[c].
  - pipa_m[c] = pipdat & enable[c] & ~plus_mode[c].
  - pipa_p[c] and pipa_m[c] are never both 1.
- Accumulator:
  - A rising edge of pipdat (same edge-detect scheme as pipasw) counts once per pulse, regardless of pulse width.
  - It adds +1 to acc[c] if the channel is enabled and in plus mode, -1 if enabled and in minus mode.
  - A disabled channel is unchanged.
  - Saturates at +(2^(AW-1)-1) and -(2^(AW-1)-1); it never wraps.
- acc_clear:
  - Synchronous; zeroes all acc on the next edge.
  - acc_clear and a count in the same cycle: clear wins, result 0.
- Simultaneous pipasw edge and pipdat edge in one cycle: the count uses the mode derived from the pre-advance frame_pos.
- Reset mid-frame:
  - All state returns to reset values immediately.
  - The first post-reset pipasw edge moves frame_pos to 1.
- Default config behaviour:
  - With FRAME=6 and plus_cnt=3, the block reproduces legacy 3-3 moding: positions 0-2 plus, 3-5 minus.
  - It advances on the pipasw edge in-domain rather than clocking on PIPASW.

Test Plan:
- Reset, enable=all 1, plus_cnt=3 on all channels, 12 pipasw pulses each followed by one pipdat pulse -> per channel 6 plus and 6 minus; acc=0; frame_strobe pulses twice, at pulses 6 and 12.
- plus_cnt ch0=6, ch1=0, ch2=4 written mid-frame, then 2 full frames of pulses:
  - First partial frame still 3-3.
  - Next frame: ch0 acc delta +6, ch1 -6, ch2 +2.
- enable[1]=0 for a full frame -> pipa_p[1]=pipa_m[1]=0 throughout; acc[1] unchanged; ch0 and ch2 unaffected.
- AW=4, plus_cnt=6, 20 pulses -> acc saturates at +7; then plus_cnt=0 for 20 pulses -> saturates at -7.
- acc_clear asserted in the same cycle as a pipdat rising edge -> acc=0 next cycle. A pipdat held high 5 cycles -> counted once. plus_cnt=9 with FRAME=6 -> behaves as 6.
- rst_n asserted at frame_pos=4 with acc=5 -> frame_pos=0, acc=0, active plus=3 immediately. Next pipasw edge gives frame_pos=1.

Source files
------------

// File: rtl/pipa_moding_sim.sv
`default_nettype none
// ============================================================================
//  Module      : pipa_moding_sim
//  Description : Multi-channel PIPA moding simulator. It splits the AGC PIPDAT
//                pulse stream into per-axis plus/minus pulses using a
//                programmable plus count per moding frame. It also provides
//                per-channel enables, frame-boundary config shadowing and
//                saturating signed net-pulse accumulators.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipa_moding_sim #(
    parameter int CHANNELS = 3,
    parameter int FRAME    = 6,
    parameter int CW       = 4,
    parameter int AW       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pipasw,
    input  logic                   pipdat,
    input  logic [CHANNELS-1:0]    enable,
    input  logic [CHANNELS*CW-1:0] plus_cnt,
    input  logic                   acc_clear,
    output logic [CHANNELS-1:0]    pipa_p,
    output logic [CHANNELS-1:0]    pipa_m,
    output logic [CW-1:0]          frame_pos,
    output logic                   frame_strobe,
    output logic [CHANNELS*AW-1:0] acc
);

    localparam logic [CW-1:0]        C_LAST  = CW'(FRAME - 1);
    localparam logic [CW-1:0]        C_FRAME = CW'(FRAME);
    localparam logic [CW-1:0]        C_HALF  = CW'(FRAME / 2);
    // Symmetric saturation limits: +(2^(AW-1)-1) and its negation.
    localparam logic signed [AW-1:0] C_MAX   = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] C_MIN   = {1'b1, {(AW-2){1'b0}}, 1'b1};

    logic          pipasw_prev_q;
    logic          pipdat_prev_q;
    logic [CW-1:0] frame_pos_q;
    logic [CW-1:0] frame_pos_d;
    logic          frame_strobe_q;
    logic          frame_strobe_d;

    logic          w_sw_rise;
    logic          w_dat_rise;
    logic          w_wrap;
    logic [CHANNELS-1:0] w_plus_mode;

    assign w_sw_rise  = pipasw & ~pipasw_prev_q;
    assign w_dat_rise = pipdat & ~pipdat_prev_q;
    assign w_wrap     = w_sw_rise & (frame_pos_q == C_LAST);

    // Edge-detect history for PIPASW and PIPDAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipasw_prev_q <= 1'b0;
            pipdat_prev_q <= 1'b0;
        end else begin
            pipasw_prev_q <= pipasw;
            pipdat_prev_q <= pipdat;
        end
    end

    // Frame position advances on each PIPASW rising edge and wraps after FRAME-1.
    always_comb begin
        frame_pos_d    = frame_pos_q;
        frame_strobe_d = w_wrap;
        if (w_sw_rise) begin
            if (w_wrap) frame_pos_d = '0;
            else        frame_pos_d = frame_pos_q + 1'b1;
        end
    end

    // Frame counter and wrap strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_pos_q    <= '0;
            frame_strobe_q <= 1'b0;
        end else begin
            frame_pos_q    <= frame_pos_d;
            frame_strobe_q <= frame_strobe_d;
        end
    end

    assign frame_pos    = frame_pos_q;
    assign frame_strobe = frame_strobe_q;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [CW-1:0]        active_q;
            logic [CW-1:0]        active_d;
            logic [CW-1:0]        w_req;
            logic signed [AW-1:0] acc_q;
            logic signed [AW-1:0] acc_d;

            assign w_req          = plus_cnt[c*CW +: CW];
            // The mode comes from registered state only, so a count landing on
            // a PIPASW edge uses the pre-advance position.
            assign w_plus_mode[c] = (frame_pos_q < active_q);

            // Shadow the requested plus count at the frame wrap, clamped to FRAME.
            always_comb begin
                active_d = active_q;
                if (w_wrap) begin
                    active_d = (w_req > C_FRAME) ? C_FRAME : w_req;
                end
            end

            // Active plus count register; resets to the legacy half/half split.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) active_q <= C_HALF;
                else        active_q <= active_d;
            end

            // Saturating net-pulse counter; clear has priority over counting.
            always_comb begin
                acc_d = acc_q;
                if (acc_clear) begin
                    acc_d = '0;
                end else if (w_dat_rise && enable[c]) begin
                    if (w_plus_mode[c]) begin
                        if (acc_q != C_MAX) acc_d = acc_q + AW'(1);
                    end else begin
                        if (acc_q != C_MIN) acc_d = acc_q - AW'(1);
                    end
                end
            end

            // Accumulator register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) acc_q <= '0;
                else        acc_q <= acc_d;
            end

            assign acc[c*AW +: AW] = acc_q;
            assign pipa_p[c]       = pipdat & enable[c] &  w_plus_mode[c];
            assign pipa_m[c]       = pipdat & enable[c] & ~w_plus_mode[c];
        end
    endgenerate

endmodule
`default_nettype wire
